// File: rtl/video_path_select.sv
// video_path_select
// Chooses per frame between bypass video and the flip stage's output. Raw
// pixels and syncs are delayed to match the flip stage latency, and mode
// changes are applied only on the active edge of the delayed vsync so a
// frame is never torn.
//
// Parameters:
//   PROC_LAT  flip-stage latency in clocks (1..8)
//   VS_POL    vsync active level (1 = active-high, 0 = active-low)
// Ports:
//   pix_1x_clk                     pixel clock, rising edge
//   reset_in                       async active-high reset; release is
//                                  expected synchronous to pix_1x_clk
//   flip_en                        async mode request (1 = flipped)
//   de_in/hsync_in/vsync_in        raw syncs
//   red_in/green_in/blue_in        raw pixel
//   red_proc/green_proc/blue_proc  flip-stage pixel, PROC_LAT clocks late
//   de_out/hsync_out/vsync_out     aligned syncs
//   red_out/green_out/blue_out     selected pixel (0 during blanking)
//   flip_active                    mode applied to the output
//   switch_pulse                   one clock when the applied mode changes
module video_path_select #(
  parameter int unsigned PROC_LAT = 1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic       pix_1x_clk,
  input  logic       reset_in,
  input  logic       flip_en,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic [7:0] red_proc,
  input  logic [7:0] green_proc,
  input  logic [7:0] blue_proc,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic       flip_active,
  output logic       switch_pulse
);

  localparam int unsigned PIX_W = 8;
  localparam int unsigned RGB_W = 3 * PIX_W;
  localparam int unsigned DLY_W = 3 + RGB_W;

  typedef enum logic [1:0] {
    ST_BYPASS      = 2'd0,
    ST_PEND_FLIP   = 2'd1,
    ST_FLIP        = 2'd2,
    ST_PEND_BYPASS = 2'd3
  } state_t;

  // Two-flop synchronizer for the switch input
  logic r_sync_meta;
  logic r_flip_req;

  always_ff @(posedge pix_1x_clk or posedge reset_in) begin
    if (reset_in) begin
      r_sync_meta <= 1'b0;
      r_flip_req  <= 1'b0;
    end else begin
      r_sync_meta <= flip_en;
      r_flip_req  <= r_sync_meta;
    end
  end

  // Delay line {de, hsync, vsync, rgb}; shifts every clock regardless of de
  logic [DLY_W-1:0]                w_dly_in;
  logic [PROC_LAT-1:0][DLY_W-1:0]  r_dly;
  logic [DLY_W-1:0]                w_dly_out;

  assign w_dly_in  = {de_in, hsync_in, vsync_in, red_in, green_in, blue_in};
  assign w_dly_out = r_dly[PROC_LAT-1];

  if (PROC_LAT == 1) begin : g_dly_one
    always_ff @(posedge pix_1x_clk or posedge reset_in) begin
      if (reset_in) r_dly <= '0;
      else          r_dly <= w_dly_in;
    end
  end else begin : g_dly_many
    always_ff @(posedge pix_1x_clk or posedge reset_in) begin
      if (reset_in) r_dly <= '0;
      else          r_dly <= {r_dly[PROC_LAT-2:0], w_dly_in};
    end
  end

  logic             w_de_d;
  logic             w_hs_d;
  logic             w_vs_d;
  logic [RGB_W-1:0] w_rgb_d;

  assign w_de_d  = w_dly_out[DLY_W-1];
  assign w_hs_d  = w_dly_out[DLY_W-2];
  assign w_vs_d  = w_dly_out[DLY_W-3];
  assign w_rgb_d = w_dly_out[RGB_W-1:0];

  // Frame edge: delayed vsync entering its active level. The history
  // register idles inactive so leaving reset cannot fake a pending edge.
  logic r_vs_prev;
  logic w_frame_edge;

  always_ff @(posedge pix_1x_clk or posedge reset_in) begin
    if (reset_in) r_vs_prev <= ~VS_POL;
    else          r_vs_prev <= w_vs_d;
  end

  assign w_frame_edge = (w_vs_d == VS_POL) && (r_vs_prev != VS_POL);

  // Mode FSM: requests wait in a pending state for the next frame edge
  state_t r_state;
  state_t w_state_nxt;
  logic   w_pulse_nxt;
  logic   w_flip_nxt;
  logic   r_flip_active;
  logic   r_switch_pulse;

  always_ff @(posedge pix_1x_clk or posedge reset_in) begin
    if (reset_in) begin
      r_state        <= ST_BYPASS;
      r_flip_active  <= 1'b0;
      r_switch_pulse <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_flip_active  <= w_flip_nxt;
      r_switch_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_BYPASS: begin
        if (r_flip_req) w_state_nxt = ST_PEND_FLIP;
      end
      ST_PEND_FLIP: begin
        // Request level in the edge clock wins over the edge itself
        if (!r_flip_req) begin
          w_state_nxt = ST_BYPASS;
        end else if (w_frame_edge) begin
          w_state_nxt = ST_FLIP;
          w_pulse_nxt = 1'b1;
        end
      end
      ST_FLIP: begin
        if (!r_flip_req) w_state_nxt = ST_PEND_BYPASS;
      end
      ST_PEND_BYPASS: begin
        if (r_flip_req) begin
          w_state_nxt = ST_FLIP;
        end else if (w_frame_edge) begin
          w_state_nxt = ST_BYPASS;
          w_pulse_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_BYPASS;
    endcase
    w_flip_nxt = (w_state_nxt == ST_FLIP) || (w_state_nxt == ST_PEND_BYPASS);
  end

  // Output stage: blank during inactive video, else pick the applied source
  logic [RGB_W-1:0] w_rgb_sel;
  logic             r_de_out;
  logic             r_hs_out;
  logic             r_vs_out;
  logic [RGB_W-1:0] r_rgb_out;

  always_comb begin
    w_rgb_sel = '0;
    if (w_de_d) begin
      if (r_flip_active) w_rgb_sel = {red_proc, green_proc, blue_proc};
      else               w_rgb_sel = w_rgb_d;
    end
  end

  always_ff @(posedge pix_1x_clk or posedge reset_in) begin
    if (reset_in) begin
      r_de_out  <= 1'b0;
      r_hs_out  <= 1'b0;
      r_vs_out  <= 1'b0;
      r_rgb_out <= '0;
    end else begin
      r_de_out  <= w_de_d;
      r_hs_out  <= w_hs_d;
      r_vs_out  <= w_vs_d;
      r_rgb_out <= w_rgb_sel;
    end
  end

  assign de_out       = r_de_out;
  assign hsync_out    = r_hs_out;
  assign vsync_out    = r_vs_out;
  assign red_out      = r_rgb_out[RGB_W-1:2*PIX_W];
  assign green_out    = r_rgb_out[2*PIX_W-1:PIX_W];
  assign blue_out     = r_rgb_out[PIX_W-1:0];
  assign flip_active  = r_flip_active;
  assign switch_pulse = r_switch_pulse;

endmodule

// File: tb/tb_video_path_select.sv
// Testbench for video_path_select: instance A (PROC_LAT=1, active-high
// vsync) and instance B (PROC_LAT=4, active-low vsync) share the pixel
// stream and switch input; each has its own vsync and reset.
module tb_video_path_select;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       flip_en;
  logic       de, hs, vs_a, vs_b;
  logic [7:0] r, g, b;
  logic [7:0] pr, pg, pb;

  logic       a_de, a_hs, a_vs, a_flip, a_pulse;
  logic [7:0] a_r, a_g, a_b;
  logic       b_de, b_hs, b_vs, b_flip, b_pulse;
  logic [7:0] b_r, b_g, b_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  video_path_select #(.PROC_LAT(1), .VS_POL(1'b1)) u_a (
    .pix_1x_clk(clk), .reset_in(rst_a), .flip_en(flip_en),
    .de_in(de), .hsync_in(hs), .vsync_in(vs_a),
    .red_in(r), .green_in(g), .blue_in(b),
    .red_proc(pr), .green_proc(pg), .blue_proc(pb),
    .de_out(a_de), .hsync_out(a_hs), .vsync_out(a_vs),
    .red_out(a_r), .green_out(a_g), .blue_out(a_b),
    .flip_active(a_flip), .switch_pulse(a_pulse)
  );

  video_path_select #(.PROC_LAT(4), .VS_POL(1'b0)) u_b (
    .pix_1x_clk(clk), .reset_in(rst_b), .flip_en(flip_en),
    .de_in(de), .hsync_in(hs), .vsync_in(vs_b),
    .red_in(r), .green_in(g), .blue_in(b),
    .red_proc(pr), .green_proc(pg), .blue_proc(pb),
    .de_out(b_de), .hsync_out(b_hs), .vsync_out(b_vs),
    .red_out(b_r), .green_out(b_g), .blue_out(b_b),
    .flip_active(b_flip), .switch_pulse(b_pulse)
  );

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic [23:0] prc;
    logic        e_de;
    logic        e_hs;
    logic        e_vs;
    logic [23:0] e_rgb;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic h, input logic v,
                       input logic [23:0] rgb, input logic [23:0] prc);
    de = d; hs = h; vs_a = v;
    {r, g, b} = rgb;
    {pr, pg, pb} = prc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] out_a();
    return 32'({a_de, a_hs, a_vs, a_r, a_g, a_b, a_flip, a_pulse});
  endfunction

  function automatic logic [31:0] out_b();
    return 32'({b_de, b_hs, b_vs, b_r, b_g, b_b, b_flip, b_pulse});
  endfunction

  logic seen_flip, seen_pulse;

  initial begin
    // Bypass vectors for A; each expectation is the output of the previous row
    vecs[0] = '{1'b1, 1'b0, 1'b0, 24'h112233, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 24'h445566, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 24'h112233};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'hABCDEF, 1'b1, 1'b1, 1'b0, 24'h445566};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 24'h010203, 24'hABCDEF, 1'b0, 1'b0, 1'b1, 24'h000000};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'hABCDEF, 1'b1, 1'b0, 1'b1, 24'h010203};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 24'h000000};

    rst_a = 1'b1; rst_b = 1'b1; flip_en = 1'b0; vs_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 24'hABCDEF);
    tick(); tick();
    // Busy inputs while reset is held must not reach the outputs
    drive(1'b1, 1'b1, 1'b1, 24'h112233, 24'hABCDEF);
    vs_b = 1'b0;
    tick();
    check("reset_a", out_a(), 32'h0);
    check("reset_b", out_b(), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 24'h0, 24'hABCDEF);
    vs_b = 1'b1;
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].rgb, vecs[i].prc);
      tick();
      check($sformatf("vec%0d", i), out_a(),
            32'({vecs[i].e_de, vecs[i].e_hs, vecs[i].e_vs, vecs[i].e_rgb, 2'b00}));
    end

    // Request withdrawn inside one frame, then a frame edge: nothing happens
    seen_flip = 1'b0; seen_pulse = 1'b0;
    flip_en = 1'b1;
    repeat (20) begin tick(); seen_flip |= a_flip; seen_pulse |= a_pulse; end
    flip_en = 1'b0;
    repeat (6) begin tick(); seen_flip |= a_flip; seen_pulse |= a_pulse; end
    drive(1'b0, 1'b0, 1'b1, 24'h0, 24'hABCDEF);
    repeat (3) begin tick(); seen_flip |= a_flip; seen_pulse |= a_pulse; end
    drive(1'b0, 1'b0, 1'b0, 24'h0, 24'hABCDEF);
    repeat (3) begin tick(); seen_flip |= a_flip; seen_pulse |= a_pulse; end
    check("cancel_flip", 32'(seen_flip), 32'h0);
    check("cancel_pulse", 32'(seen_pulse), 32'h0);

    // Deferred switch to flipped
    seen_flip = 1'b0;
    flip_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 24'h102030, 24'hABCDEF);
    repeat (8) begin tick(); seen_flip |= a_flip; end
    check("pend_no_flip", 32'(seen_flip), 32'h0);
    check("pend_bypass_pix", 32'({a_de, a_r, a_g, a_b}), 32'({1'b1, 24'h102030}));
    drive(1'b0, 1'b0, 1'b1, 24'h102030, 24'hABCDEF);
    tick();
    check("edge_clock", 32'({a_flip, a_pulse}), 32'h0);
    tick();
    check("switch_flip", 32'({a_vs, a_flip, a_pulse}), 32'h7);
    tick();
    check("pulse_one_clk", 32'({a_flip, a_pulse}), 32'h2);
    drive(1'b1, 1'b0, 1'b0, 24'h102030, 24'hABCDEF);
    tick(); tick();
    check("flip_pix", 32'({a_de, a_r, a_g, a_b}), 32'({1'b1, 24'hABCDEF}));

    // Switch back to bypass at the next frame edge
    flip_en = 1'b0;
    repeat (6) tick();
    check("pend_bypass_hold", 32'({a_flip, a_pulse, a_r, a_g, a_b}), 32'({2'b10, 24'hABCDEF}));
    drive(1'b0, 1'b0, 1'b1, 24'h102030, 24'hABCDEF);
    tick();
    check("back_edge_clock", 32'({a_flip, a_pulse}), 32'h2);
    tick();
    check("back_switch", 32'({a_flip, a_pulse}), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 24'h102030, 24'hABCDEF);
    tick(); tick();
    check("back_pix", 32'({a_de, a_r, a_g, a_b}), 32'({1'b1, 24'h102030}));

    // Flip again, then reset mid-line
    flip_en = 1'b1;
    repeat (4) tick();
    drive(1'b0, 1'b0, 1'b1, 24'h102030, 24'hABCDEF);
    tick(); tick();
    check("reflip", 32'({a_flip, a_pulse}), 32'h3);
    drive(1'b1, 1'b0, 1'b0, 24'h102030, 24'hABCDEF);
    tick(); tick(); tick();
    check("pre_reset_pix", 32'({a_de, a_r, a_g, a_b, a_flip}), 32'({1'b1, 24'hABCDEF, 1'b1}));
    #2 rst_a = 1'b1;
    #1;
    check("reset_async", out_a(), 32'h0);
    flip_en = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 24'hABCDEF);
    tick(); tick();
    rst_a = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'h445566, 24'hABCDEF);
    tick();
    check("post_reset_fill", 32'(a_de), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 24'h0, 24'hABCDEF);
    tick();
    check("post_reset_bypass", 32'({a_de, a_r, a_g, a_b, a_flip}), 32'({1'b1, 24'h445566, 1'b0}));

    // Instance B: four-clock flip stage, active-low vsync
    rst_b = 1'b1; vs_b = 1'b1;
    tick(); tick();
    rst_b = 1'b0;
    repeat (6) tick();
    drive(1'b1, 1'b0, 1'b0, 24'h0A0B0C, 24'hABCDEF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 24'h0, 24'hABCDEF);
    tick(); tick(); tick();
    check("b_lat4", 32'(b_de), 32'h0);
    tick();
    check("b_lat5", 32'({b_de, b_r, b_g, b_b}), 32'({1'b1, 24'h0A0B0C}));

    vs_b = 1'b0;
    repeat (10) tick();
    flip_en = 1'b1;
    repeat (10) tick();
    check("b_pending", 32'(b_flip), 32'h0);
    seen_flip = 1'b0;
    vs_b = 1'b1;
    repeat (10) begin tick(); seen_flip |= b_flip | b_pulse; end
    check("b_rise_ignored", 32'(seen_flip), 32'h0);
    vs_b = 1'b0;
    repeat (4) tick();
    check("b_fall_wait", 32'({b_flip, b_pulse}), 32'h0);
    tick();
    check("b_fall_switch", 32'({b_flip, b_pulse}), 32'h3);
    drive(1'b1, 1'b0, 1'b0, 24'h0A0B0C, 24'hABCDEF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 24'h0, 24'hABCDEF);
    repeat (4) tick();
    check("b_flip_pix", 32'({b_de, b_r, b_g, b_b}), 32'({1'b1, 24'hABCDEF}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_path_select.md
Name: video_path_select

Overview:
- Downstream of the horizontal flip stage; sits between the flip stage and the HDMI output encoder.
- Selects per frame between the raw input video (bypass) and the flipped video from the flip stage.
- Delays raw pixels and syncs (de, hsync, vsync) so they align with the flip stage's output latency.
- Applies mode changes only at a frame boundary so no frame is ever torn.

Parameters:
- PROC_LAT, 1, flip-stage latency in clocks from raw pixel input to processed pixel output (1..8).
- VS_POL, 1, vsync active level (1 = active-high, 0 = active-low).

Ports:
- pix_1x_clk  input  1  pixel clock, all logic on rising edge
- reset_in  input  1  asynchronous, active-high reset
- flip_en  input  1  mode request from slide switch, asynchronous to pix_1x_clk (1 = flipped)
- de_in  input  1  raw data enable
- hsync_in  input  1  raw hsync
- vsync_in  input  1  raw vsync
- red_in, green_in, blue_in  input  8 each  raw pixel
- red_proc, green_proc, blue_proc  input  8 each  flip-stage output, valid PROC_LAT clocks after the matching raw pixel
- de_out, hsync_out, vsync_out  output  1 each  aligned syncs
- red_out, green_out, blue_out  output  8 each  selected pixel
- flip_active  output  1  mode currently applied to output (1 = flipped)
- switch_pulse  output  1  one-clock pulse when applied mode changes

Behaviour:
- Reset (async assert, sync release): all outputs 0; delay line cleared; synchronizer cleared; FSM in BYPASS; flip_active = 0.
- flip_en passes through a 2-FF synchronizer; flip_req = second FF.
- Delay line: PROC_LAT-deep shift register carrying {de, hsync, vsync, raw RGB} (27 bits); shifts every clock, independent of de.
- Delayed vsync = vs_d. Frame edge = vs_d transitions to its active level (VS_POL) this clock vs previous clock. Edge-detect register resets to the inactive level, so no spurious edge after reset.
- Output register, 1 clock:
  - de_out/hsync_out/vsync_out = delayed syncs.
  - If delayed de = 0: RGB out = 0.
  - Else if flip_active = 1: RGB out = proc inputs.
  - Else: RGB out = delayed raw RGB.
- Total latency: raw input at cycle t appears on outputs at cycle t + PROC_LAT + 1 (rising edges counted after t).
- FSM states and transitions:
  - BYPASS: flip_req = 1 -> PEND_FLIP.
  - PEND_FLIP: flip_req = 0 -> BYPASS (cancel, no pulse); frame edge with flip_req = 1 -> FLIP and assert switch_pulse.
  - FLIP: flip_req = 0 -> PEND_BYPASS.
  - PEND_BYPASS: flip_req = 1 -> FLIP (cancel, no pulse); frame edge with flip_req = 0 -> BYPASS and assert switch_pulse.
- flip_active = 1 in FLIP and PEND_BYPASS.
- The new mode takes effect on the first output pixel registered after the switching edge. The entire vsync-active region and the following frame use the new mode.
- Simultaneous frame edge and flip_req change:
  - The flip_req value in the edge clock decides.
  - If it equals the current mode, cancel and stay; no pulse.
- Repeated edges with no pending request: no action.
- Reset mid-frame: output drops to 0 immediately. After release, output resumes bypass once the delay line refills (PROC_LAT + 1 clocks).
- switch_pulse is high exactly one clock, coincident with the first clock flip_active holds its new value.

Test Plan:
- Latency, PROC_LAT = 1, bypass: de_in = 1 with raw pixel 0x112233 at cycle 10 -> {red_out, green_out, blue_out} = 0x112233 and de_out = 1 at cycle 12. hsync/vsync delayed identically.
- Blanking: de_in = 0 with raw 0xFFFFFF and proc 0xABCDEF -> RGB out = 0x000000.
- Deferred switch: flip_en rises mid-frame -> flip_active stays 0 until the clock after vs_d goes active. Then switch_pulse = 1 for one clock, and the next active pixel out equals proc input (0xABCDEF), not raw.
- Cancel: flip_en pulses high for 20 clocks within one frame with no vsync -> flip_active stays 0 and switch_pulse never asserts.
- VS_POL = 0 with PROC_LAT = 4: vsync falling edge triggers the pending switch; a rising edge does not. Latency = 5 clocks.
- Async reset asserted mid-line in FLIP -> all outputs 0 within the same clock period, flip_active = 0. After release, bypass pixel output returns 2 clocks after the first de_in (PROC_LAT = 1).
